// File: rtl/tim_pkg.sv
// Shared definitions for the tim timer peripheral: bus widths, register
// offsets and bit positions inside CTRL and STATUS.
package tim_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  localparam logic [7:0] TIM_CTRL   = 8'h00;
  localparam logic [7:0] TIM_PSC    = 8'h04;
  localparam logic [7:0] TIM_CNT    = 8'h08;
  localparam logic [7:0] TIM_CMP    = 8'h0C;
  localparam logic [7:0] TIM_STATUS = 8'h10;

  localparam int TIM_EN_BIT      = 0;
  localparam int TIM_ONESHOT_BIT = 1;
  localparam int TIM_IRQEN_BIT   = 2;
  localparam int TIM_MATCH_BIT   = 0;

  typedef struct packed {
    logic irq_en;
    logic oneshot;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/tim_prescaler.sv
// Prescaler for tim: emits a one-cycle tick every psc+1 enabled cycles.
// Held at zero while disabled so a fresh enable always starts a full period.
module tim_prescaler import tim_pkg::*; #(
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [PSC_W-1:0] psc,
  output logic             tick
);

  logic [PSC_W-1:0] psc_cnt_q;
  logic [PSC_W-1:0] psc_cnt_d;

  // Tick on terminal count, then wrap; otherwise step while enabled
  always_comb begin
    tick      = en && (psc_cnt_q == psc);
    psc_cnt_d = '0;
    if (en && !tick) begin
      psc_cnt_d = psc_cnt_q + PSC_W'(1);
    end
  end

  // Prescaler count register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      psc_cnt_q <= '0;
    end else begin
      psc_cnt_q <= psc_cnt_d;
    end
  end

endmodule

// File: rtl/tim.sv
// tim: memory-mapped 32-bit timer with prescaler, compare match, one-shot
// mode and a level interrupt. Define TIM_PWM_EN to add the pwm_o output.
module tim import tim_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          PSC_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BUS_AW-1:0] tim_addr_i,
  input  logic [BUS_DW-1:0] tim_data_i,
  input  logic              tim_we_i,
  input  logic              tim_re_i,
  output logic [BUS_DW-1:0] tim_data_o,
  output logic              tim_irq
`ifdef TIM_PWM_EN
  ,
  output logic              pwm_o
`endif
);

  ctrl_t             ctrl_q,  ctrl_d;
  logic [PSC_W-1:0]  psc_q,   psc_d;
  logic [31:0]       cnt_q,   cnt_d;
  logic [31:0]       cmp_q,   cmp_d;
  logic              match_q, match_d;
  logic              irq_q,   irq_d;
  logic [BUS_DW-1:0] rdata_q, rdata_d;
  logic [BUS_DW-1:0] rd_val;
  logic [7:0]        offset;
  logic              sel;
  logic              wr;
  logic              rd;
  logic              tick;
  logic              match_hit;

  tim_prescaler #(.PSC_W(PSC_W)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ctrl_q.en),
    .psc   (psc_q),
    .tick  (tick)
  );

  // Address decode and read-data mux over the current register values
  always_comb begin
    sel    = (tim_addr_i[31:8] == BASE_ADDR[31:8]);
    offset = tim_addr_i[7:0];
    wr     = tim_we_i && sel;
    rd     = tim_re_i && sel;
    rd_val = '0;
    case (offset)
      TIM_CTRL: begin
        rd_val[TIM_EN_BIT]      = ctrl_q.en;
        rd_val[TIM_ONESHOT_BIT] = ctrl_q.oneshot;
        rd_val[TIM_IRQEN_BIT]   = ctrl_q.irq_en;
      end
      TIM_PSC:    rd_val[PSC_W-1:0]    = psc_q;
      TIM_CNT:    rd_val               = cnt_q;
      TIM_CMP:    rd_val               = cmp_q;
      TIM_STATUS: rd_val[TIM_MATCH_BIT] = match_q;
      default:    rd_val               = '0;
    endcase
  end

  // Next state: counter events first, bus writes last so they win conflicts,
  // except that a fresh match beats a STATUS clear
  always_comb begin
    match_hit = tick && (cnt_q == cmp_q);
    ctrl_d    = ctrl_q;
    psc_d     = psc_q;
    cnt_d     = cnt_q;
    cmp_d     = cmp_q;
    match_d   = match_q;
    irq_d     = match_q && ctrl_q.irq_en;
    rdata_d   = rd ? rd_val : rdata_q;

    if (tick) begin
      if (match_hit) begin
        cnt_d = '0;
        if (ctrl_q.oneshot) begin
          ctrl_d.en = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    if (wr) begin
      case (offset)
        TIM_CTRL: begin
          ctrl_d.en      = tim_data_i[TIM_EN_BIT];
          ctrl_d.oneshot = tim_data_i[TIM_ONESHOT_BIT];
          ctrl_d.irq_en  = tim_data_i[TIM_IRQEN_BIT];
        end
        TIM_PSC:    psc_d = tim_data_i[PSC_W-1:0];
        TIM_CNT:    cnt_d = tim_data_i;
        TIM_CMP:    cmp_d = tim_data_i;
        TIM_STATUS: begin
          if (tim_data_i[TIM_MATCH_BIT]) begin
            match_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (match_hit) begin
      match_d = 1'b1;
    end
  end

  // Register file, status, interrupt and read-data flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      psc_q   <= '0;
      cnt_q   <= '0;
      cmp_q   <= '0;
      match_q <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      psc_q   <= psc_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign tim_data_o = rdata_q;
  assign tim_irq    = irq_q;

`ifdef TIM_PWM_EN
  logic pwm_q, pwm_d;

  // PWM level is high while the count is still below the compare value
  always_comb begin
    pwm_d = ctrl_q.en && (cnt_q < cmp_q);
  end

  // PWM output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;
`endif

endmodule
